// File: rtl/ras_unit.sv
// ras_unit: return-address stack predictor for jal / jr $ra pairs.
// Circular DEPTH x AW entry array with a top pointer and a valid count.
// Optional build macro RAS_OVERFLOW_WRAP_EN: when defined, a push onto a
// full stack overwrites the oldest entry; when undefined, it is dropped.
// Overflow and underflow are sticky flags. Mispredicts are counted with a
// 16-bit saturating counter.
module ras_unit #(
  parameter int DEPTH = 8,
  parameter int AW    = 32
) (
  input  logic                       CLK,
  input  logic                       reset,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  input  logic [AW-1:0]              pop_actual,
  output logic [AW-1:0]              pred_addr,
  output logic                       pred_valid,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       mispredict,
  output logic [15:0]                miss_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] entries_r [DEPTH];
  logic [PW-1:0] top_r;
  logic [PW:0]   count_r;
  logic          overflow_r;
  logic          underflow_r;
  logic          mispredict_r;
  logic [15:0]   miss_cnt_r;

  logic          empty_s;
  logic          full_s;
  logic          wr_en_s;
  logic [PW-1:0] wr_idx_s;
  logic [PW-1:0] top_nxt_s;
  logic [PW:0]   count_nxt_s;
  logic          ovf_set_s;
  logic          unf_set_s;
  logic          miss_eval_s;
  logic          mis_nxt_s;

  assign empty_s    = (count_r == {(PW+1){1'b0}});
  assign full_s     = (count_r == FULL_CNT);
  assign pred_valid = ~empty_s;
  assign pred_addr  = empty_s ? {AW{1'b0}} : entries_r[top_r];
  assign count      = count_r;
  assign full       = full_s;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;
  assign mispredict = mispredict_r;
  assign miss_cnt   = miss_cnt_r;

  // Next-state decode for the push/pop combinations against the current fill level.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_idx_s    = top_r;
    top_nxt_s   = top_r;
    count_nxt_s = count_r;
    ovf_set_s   = 1'b0;
    unf_set_s   = 1'b0;
    miss_eval_s = 1'b0;
    case ({push, pop})
      2'b10: begin
        if (!full_s) begin
          wr_en_s     = 1'b1;
          wr_idx_s    = top_r + 1'b1;
          top_nxt_s   = top_r + 1'b1;
          count_nxt_s = count_r + 1'b1;
        end else begin
          ovf_set_s = 1'b1;
`ifdef RAS_OVERFLOW_WRAP_EN
          // The slot above top is the oldest entry once the ring is full.
          wr_en_s   = 1'b1;
          wr_idx_s  = top_r + 1'b1;
          top_nxt_s = top_r + 1'b1;
`else
          wr_en_s   = 1'b0;
`endif
        end
      end
      2'b01: begin
        if (empty_s) begin
          unf_set_s = 1'b1;
        end else begin
          top_nxt_s   = top_r - 1'b1;
          count_nxt_s = count_r - 1'b1;
          miss_eval_s = 1'b1;
        end
      end
      2'b11: begin
        if (empty_s) begin
          // Nothing to pop: the push still lands as on an empty stack.
          unf_set_s   = 1'b1;
          wr_en_s     = 1'b1;
          wr_idx_s    = top_r + 1'b1;
          top_nxt_s   = top_r + 1'b1;
          count_nxt_s = count_r + 1'b1;
        end else begin
          // Pop then push collapses to replacing the top entry in place.
          wr_en_s     = 1'b1;
          wr_idx_s    = top_r;
          miss_eval_s = 1'b1;
        end
      end
      default: begin
        wr_en_s = 1'b0;
      end
    endcase
    mis_nxt_s = miss_eval_s && (pred_addr != pop_actual);
  end

  // Entry array write; entries are deliberately left untouched by reset.
  always_ff @(posedge CLK) begin
    if (wr_en_s && !reset) begin
      entries_r[wr_idx_s] <= push_addr;
    end
  end

  // Pointer, count, sticky flags, mispredict pulse and saturating miss counter.
  always_ff @(posedge CLK) begin
    if (reset) begin
      top_r        <= {PW{1'b0}};
      count_r      <= {(PW+1){1'b0}};
      overflow_r   <= 1'b0;
      underflow_r  <= 1'b0;
      mispredict_r <= 1'b0;
      miss_cnt_r   <= 16'h0000;
    end else begin
      top_r        <= top_nxt_s;
      count_r      <= count_nxt_s;
      overflow_r   <= overflow_r | ovf_set_s;
      underflow_r  <= underflow_r | unf_set_s;
      mispredict_r <= mis_nxt_s;
      if (mis_nxt_s && (miss_cnt_r != 16'hFFFF)) begin
        miss_cnt_r <= miss_cnt_r + 16'h0001;
      end
    end
  end

endmodule
